// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 32-bit select mux.
// Registers a one-hot grant and the mux select; a hold counter bounds bursts when others wait.
module mux16_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t      state, state_n;
    logic [3:0]  owner, owner_n;
    logic [3:0]  last, last_n;
    logic [7:0]  hold_cnt, hold_n;
    logic [15:0] others;
    logic [3:0]  win_req, win_others;

    // First set bit of mask, scanning from (from+1) upward with 4-bit wrap.
    function automatic logic [3:0] pick(input logic [15:0] mask, input logic [3:0] from);
        logic [3:0] idx;
        logic       found;
        pick  = 4'd0;
        found = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            idx = from + 4'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign others     = req & ~(16'd1 << owner);
    assign win_req    = pick(req, last);
    assign win_others = pick(others, last);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (req != 16'd0) begin
                    state_n = GRANT;
                    owner_n = win_req;
                    last_n  = win_req;
                    hold_n  = 8'd1;
                end
            end
            GRANT: begin
                if (req[owner] && (hold_cnt < HOLD_MAX || others == 16'd0)) begin
                    if (hold_cnt < HOLD_MAX)
                        hold_n = hold_cnt + 8'd1;
                end else if (others != 16'd0) begin
                    // Covers both preemption at HOLD_MAX and direct hand-off on release.
                    owner_n = win_others;
                    last_n  = win_others;
                    hold_n  = 8'd1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 4'd0;
            last     <= 4'd15;
            hold_cnt <= 8'd0;
            gnt      <= 16'd0;
            sel      <= 4'd0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            gnt      <= (state_n == GRANT) ? (16'd1 << owner_n) : 16'd0;
            sel      <= owner_n;
            busy     <= (state_n == GRANT);
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with MAX_HOLD=4; expected values are hand-computed.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;

    int n_cmp;
    int n_bad;

    mux16_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [15:0] eg, input logic [3:0] es, input logic eb);
        check({tag, ".gnt"},  32'(gnt),  32'(eg));
        check({tag, ".sel"},  32'(sel),  32'(es));
        check({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        req   = 16'd0;

        // Reset state, single requester grant and release.
        do_reset();
        check_out("rst", 16'h0000, 4'd0, 1'b0);
        req = 16'h0001;
        tick();
        check_out("single_grant", 16'h0001, 4'd0, 1'b1);
        tick();
        tick();
        check_out("single_hold", 16'h0001, 4'd0, 1'b1);
        req = 16'h0000;
        tick();
        check_out("single_release", 16'h0000, 4'd0, 1'b0);

        // Hand-off without an idle bubble.
        do_reset();
        req = 16'h8001;
        tick();
        check_out("handoff_first", 16'h0001, 4'd0, 1'b1);
        req = 16'h8000;
        tick();
        check_out("handoff_next", 16'h8000, 4'd15, 1'b1);

        // Wrap-around: last owner 15, release to idle, then search wraps to 0.
        req = 16'h0000;
        tick();
        check_out("wrap_idle", 16'h0000, 4'd15, 1'b0);
        req = 16'h4002;
        tick();
        check_out("wrap_first", 16'h0002, 4'd1, 1'b1);
        req = 16'h4000;
        tick();
        check_out("wrap_next", 16'h4000, 4'd14, 1'b1);

        // Preemption with MAX_HOLD=4: four cycles each, alternating.
        do_reset();
        req = 16'h0003;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (((i / 4) % 2) == 0)
                check_out($sformatf("preempt_%0d", i), 16'h0001, 4'd0, 1'b1);
            else
                check_out($sformatf("preempt_%0d", i), 16'h0002, 4'd1, 1'b1);
        end

        // Lone requester holds indefinitely, then saturated counter yields at once.
        do_reset();
        req = 16'h0010;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("lone_%0d", i), 32'(gnt), 32'h0010);
        end
        req = 16'h0030;
        tick();
        check_out("lone_yield", 16'h0020, 4'd5, 1'b1);

        // Reset mid-grant drops the owner; search restarts at index 0.
        do_reset();
        req = 16'h0300;
        tick();
        check_out("midrst_grant", 16'h0100, 4'd8, 1'b1);
        reset = 1'b1;
        tick();
        check_out("midrst_reset", 16'h0000, 4'd0, 1'b0);
        reset = 1'b0;
        tick();
        check_out("midrst_regrant", 16'h0100, 4'd8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter that shares one 16-input, 32-bit select mux (`Mux32bits_16`) among 16 requesters. It registers a one-hot grant and drives the mux's 4-bit `sel` directly. Long bursts are bounded by a hold counter, so one requester cannot starve the others. It sits between requesting datapath units and the shared 16:1 result mux.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another request is pending; legal range 1..255.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  16: level request; bit i held high while requester i wants or uses the mux.
- `gnt`  out  16: registered one-hot grant; all zero when idle.
- `sel`  out  4: binary index of the current owner, wired to the mux select.
- `busy`  out  1: high when `gnt` is nonzero.

## Operation
- Two states: IDLE and GRANT. Internal state:
  - `owner[3:0]`: current or most recent winner.
  - `last[3:0]`: search pointer.
  - `hold_cnt[7:0]`.
- Winner search: the first set bit of the candidate mask, scanning from index (`last`+1) mod 16 upward and wrapping 15→0.
- IDLE:
  - If `req`≠0: pick the winner from `req`, set `owner`=`last`=winner and `hold_cnt`=1, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, evaluated each edge with `others` = `req` with bit `owner` masked off:
  - If `req[owner]`=1 and (`hold_cnt`<`MAX_HOLD` or `others`=0): stay. `hold_cnt` increments and saturates at `MAX_HOLD`.
  - If `req[owner]`=1, `hold_cnt`=`MAX_HOLD` and `others`≠0: preempt. The winner is picked from `others`; stay in GRANT with `hold_cnt`=1.
  - If `req[owner]`=0 and `others`≠0: hand off directly to the winner picked from `others`. There is no idle bubble; `hold_cnt`=1.
  - If `req[owner]`=0 and `others`=0: go to IDLE with `gnt`=0.
- Outputs:
  - `gnt` = one-hot of `owner` in GRANT, 0 in IDLE.
  - `busy` = (state==GRANT).
  - `sel` = `owner` in both states. In IDLE it keeps the last owner so the mux output stays stable.
- The grant is never asserted to a bit whose `req` was low at the deciding edge. Exactly one `gnt` bit is high in GRANT.
- Reset values:
  - state = IDLE.
  - `gnt` = 0, `busy` = 0, `sel` = 0, `owner` = 0, `hold_cnt` = 0.
  - `last` = 15, so the first search starts at index 0.
- Reset has priority over all transitions, including mid-grant. The current owner is dropped without notice.

## Timing
- Request to grant:
  - `req` sampled high at edge k in IDLE gives `gnt`/`sel`/`busy` valid after edge k.
  - Minimum latency is one cycle; there is no combinational req→gnt path.
- Release: owner `req` sampled low at edge k gives the new grant, or `gnt`=0, after edge k. The owner must tolerate one cycle of `gnt` after it deasserts `req`.
- Preemption: an owner with competing requests holds `gnt` for exactly `MAX_HOLD` consecutive cycles. It switches at the edge where `hold_cnt`=`MAX_HOLD`.
- Lone requester: holds indefinitely, with `hold_cnt` saturated.
- Fairness: a pending requester is granted within 15×`MAX_HOLD` cycles.
- `MAX_HOLD`=1: a new arbitration every cycle while competing requests exist.
- `sel` and `gnt` always change on the same edge.

## Test plan
- Reset with `req`=0, then `req`=0x0001 for 3 cycles, then 0 → `gnt`=0x0001, `sel`=0, `busy`=1 one cycle after `req` rises. `gnt`=0 and `busy`=0 one cycle after the drop; `sel` stays 0.
- After reset, `req`=0x8001 → `gnt`=0x0001 first. Drop bit 0 (`req`=0x8000) → next cycle `gnt`=0x8000, `sel`=15, no idle cycle.
- Wrap-around: `last`=15 (granted 15, then released to idle), `req`=0x4002 → `gnt`=0x0002, `sel`=1. Drop bit 1 → `gnt`=0x4000, `sel`=14.
- `MAX_HOLD`=4, `req`=0x0003 held constantly → `gnt` shows 0x0001 for 4 cycles, 0x0002 for 4 cycles, then repeats.
- `MAX_HOLD`=4, `req`=0x0010 held 20 cycles → `gnt`=0x0010 all 20 cycles, no preemption. Then raise bit 5 → `gnt`=0x0020 within 1 cycle, since `hold_cnt` is already saturated.
- `req`=0x0300 granted to bit 8, then `reset` pulse for 1 cycle → `gnt`=0, `sel`=0, `busy`=0 the cycle after reset. With `req` still 0x0300, the first grant after reset is bit 8, because the search restarts at 0.
